dac_tdm_drv: RTL and testbench
==============================

// Module: dac_tdm_drv
// PURPOSE
//  Parametrised serial-audio DAC driver: NCH channels, DATA_W-bit samples in SLOT_W-bit slots.
//  Supports left-justified, I2S and right-justified formats: 2-ch LR clock, or TDM frame-sync pulse when NCH>2.
//  Sits between the mixer output and the DAC pins. Frame-coherent double buffer; pops one frame of samples per frame.
// PARAMETERS
//  DATA_W   24  sample width (bits, two's complement)
//  SLOT_W   32  bits per channel slot; must be > DATA_W
//  NCH      2   channels per frame; >= 2
//  BCK_DIV  2   clk cycles per bck period; even, >= 2
//  CHW      $clog2(NCH)  channel index width (localparam)
// PORTS
//  clk       in   1       master clock (sck_o source)
//  rst       in   1       synchronous reset, active high
//  fmt_i     in   2       0=left-justified, 1=I2S, 2=right-justified, 3=reserved (acts as 0)
//  data_i    in   DATA_W  sample to stage
//  ch_i      in   CHW     channel index for data_i
//  valid_i   in   1       write data_i into staging[ch_i] this cycle
//  pop_o     out  1       1-cycle request: supply next frame's NCH samples
//  sck_o     out  1       = clk
//  bck_o     out  1       bit clock
//  lrck_o    out  1       LR clock (NCH==2) / frame sync (NCH>2)
//  data_o    out  1       serial data, MSB first
//  underrun_o out 1       sticky underrun flag (see CONFIGURATION)
// BEHAVIOUR
//  - Counter cnt: 0..NCH*SLOT_W*BCK_DIV-1, +1 per clk, wraps to 0. slot s, bit b, phase p are derived from cnt.
//  - Reset: cnt=0; bck_o, lrck_o, data_o, pop_o, underrun_o = 0; staging, frame buffer and fmt register cleared to 0 / fmt 0.
//  - bck_o = 0 for the first BCK_DIV/2 clks of each bit period, 1 for the second half. DAC samples on the rising edge.
//  - data_o is registered and changes only at the bck falling edge (p==0); it is stable through the rising edge.
//  - Frame boundary is the clk where cnt == max. On that clk:
//    - frame buffer <= staging (all NCH entries);
//    - fmt register <= fmt_i. fmt_i changes mid-frame have no effect until the boundary.
//  - pop_o = 1 exactly on clks with cnt==0 and not in reset. First pop is on the first clk after rst deasserts.
//  - Staging write: valid_i -> staging[ch_i] <= data_i. ch_i >= NCH is ignored.
//    A write on the boundary clk is not seen by that copy; it lands in staging for the next frame.
//  - Bit mapping, sample X = framebuf[s] (bits outside these ranges are 0):
//    - LJ: bit b < DATA_W outputs X[DATA_W-1-b].
//    - I2S: 1 <= b <= DATA_W outputs X[DATA_W-b].
//    - RJ: b >= SLOT_W-DATA_W outputs X[SLOT_W-1-b].
//  - lrck_o (registered, aligned with data_o):
//    - NCH==2, LJ/RJ: 1 during slot 0, 0 during slot 1.
//    - NCH==2, I2S: 0 during slot 0, 1 during slot 1.
//    - NCH>2: 1 only for bit 0 of slot 0 (one bck wide), all formats.
//  - Reset mid-frame: everything returns to reset state next clk; frame restarts at cnt=0 with zero data.
//  - Latency: a sample staged before boundary k is output in the frame beginning at cnt==0 after boundary k.
//    Its MSB appears on data_o at bit 0 (LJ), bit 1 (I2S) or bit SLOT_W-DATA_W (RJ) of its slot.
// CONFIGURATION
//  DAC_TDM_UNDERRUN_EN defined:
//   - A per-channel written-flag is set by valid_i and cleared at each boundary copy.
//   - At a boundary, each channel whose flag is clear is copied as 0 (not the stale value), and underrun_o is set.
//   - underrun_o stays set until rst.
//  DAC_TDM_UNDERRUN_EN undefined:
//   - No flags; the boundary copy always copies staging, so stale samples repeat.
//   - underrun_o is tied to 0.
// TESTING
//  1 Defaults, fmt=0: stage L=24'hABCDEF, R=24'h123456 after first pop.
//    -> next frame: bits 0..23 = L MSB-first, bits 24..31 = 0; lrck_o=1 in slot 0, 0 in slot 1; 128 clk/frame.
//  2 fmt=1, same data -> slot 0 bit 0 = 0, bits 1..24 = ABCDEF; lrck_o 0 then 1.
//    fmt=2 -> data occupies bits 8..31.
//  3 NCH=8, SLOT_W=32, BCK_DIV=4: stage ch k = k+1 -> 1024-clk frame; lrck_o high for exactly 4 clks at frame start;
//    slot k carries 24'h(k+1) left-justified; pop_o period 1024 clks.
//  4 Write valid_i on the boundary clk with ch0 = 24'h7FFFFF -> current frame's copy keeps the old ch0;
//    24'h7FFFFF appears one frame later.
//  5 Assert rst for 1 clk mid-slot 1 -> next clk all outputs 0 and cnt=0; pop_o on the first clk after release; data all 0.
//  6 With DAC_TDM_UNDERRUN_EN: stage only ch0 in a frame -> ch1 slot outputs all 0 and underrun_o=1, held until rst.
//    Without the macro: ch1 repeats its old value and underrun_o=0.

Source files
------------

// File: rtl/dac_tdm_drv.sv
// dac_tdm_drv: serial-audio DAC driver for NCH channels of DATA_W-bit samples in SLOT_W-bit slots.
// Supports left-justified, I2S and right-justified formats. With NCH==2, lrck_o is an LR clock.
// With NCH>2, lrck_o is a one-bit-wide frame-sync pulse.
// Samples are staged by the mixer and then copied as a whole frame into the frame buffer at the
// frame boundary.
//
// Optional feature: define DAC_TDM_UNDERRUN_EN to enable the per-channel written flags. With the
// macro defined, channels that were not written during a frame are emitted as zero and the sticky
// underrun_o flag is set. Without the macro, stale samples repeat and underrun_o is tied to 0.
//
// Ports:
//   clk        master clock, forwarded on sck_o
//   rst        synchronous reset, active high
//   fmt_i      0=LJ, 1=I2S, 2=RJ, 3=reserved (treated as LJ); latched at the frame boundary
//   data_i     sample to stage; ch_i selects the channel, valid_i qualifies the write
//   pop_o      one-cycle request for the next frame's samples (cnt==0)
//   sck_o      = clk
//   bck_o      bit clock: low for the first half of each bit period, high for the second half
//   lrck_o     LR clock / frame sync, registered and aligned with data_o
//   data_o     serial data, MSB first, changes on bck falling edges
//   underrun_o sticky underrun flag
module dac_tdm_drv #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned SLOT_W  = 32,
  parameter int unsigned NCH     = 2,
  parameter int unsigned BCK_DIV = 2,
  localparam int unsigned CHW    = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        fmt_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CHW-1:0]    ch_i,
  input  logic              valid_i,
  output logic              pop_o,
  output logic              sck_o,
  output logic              bck_o,
  output logic              lrck_o,
  output logic              data_o,
  output logic              underrun_o
);

  localparam int unsigned PH_W  = $clog2(BCK_DIV);
  localparam int unsigned BIT_W = $clog2(SLOT_W);

  localparam logic [PH_W-1:0]  PhMax   = PH_W'(BCK_DIV - 1);
  localparam logic [PH_W-1:0]  PhHalf  = PH_W'(BCK_DIV / 2);
  localparam logic [BIT_W-1:0] BitMax  = BIT_W'(SLOT_W - 1);
  localparam logic [CHW-1:0]   SlotMax = CHW'(NCH - 1);

  localparam logic [1:0] FmtLj  = 2'd0;
  localparam logic [1:0] FmtI2s = 2'd1;
  localparam logic [1:0] FmtRj  = 2'd2;

  // The frame counter cnt is kept as cascaded phase / bit / slot fields, so no divider is needed.
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [CHW-1:0]    slot_q, slot_d;
  logic              boundary;

  logic [DATA_W-1:0] stg_q  [NCH];
  logic [DATA_W-1:0] stg_d  [NCH];
  logic [DATA_W-1:0] fbuf_q [NCH];
  logic [DATA_W-1:0] fbuf_d [NCH];
  logic [1:0]        fmt_q, fmt_d;

  logic              bck_q, bck_d;
  logic              lrck_q, lrck_d;
  logic              data_q, data_d;

  logic              ch_ok;
  logic [1:0]        fmt_eff;
  logic [DATA_W-1:0] sample;
  logic [SLOT_W-1:0] word_lj, word;
  logic [BIT_W-1:0]  idx;

  // Out-of-range channel indices only exist when NCH is not a power of two.
  if (NCH == (1 << CHW)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = ({1'b0, ch_i} < (CHW+1)'(NCH));
  end

  always_comb begin
    ph_d   = ph_q + 1'b1;
    bit_d  = bit_q;
    slot_d = slot_q;
    if (ph_q == PhMax) begin
      ph_d  = '0;
      bit_d = bit_q + 1'b1;
      if (bit_q == BitMax) begin
        bit_d  = '0;
        slot_d = (slot_q == SlotMax) ? '0 : slot_q + 1'b1;
      end
    end
  end

  assign boundary = (ph_q == PhMax) && (bit_q == BitMax) && (slot_q == SlotMax);

`ifdef DAC_TDM_UNDERRUN_EN
  logic [NCH-1:0] wr_q, wr_d;
  logic           under_q, under_d;

  // A write on the boundary clock belongs to the next frame, so it survives the clear.
  always_comb begin
    wr_d = boundary ? '0 : wr_q;
    if (valid_i && ch_ok) begin
      wr_d[ch_i] = 1'b1;
    end
    under_d = under_q | (boundary && !(&wr_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      under_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      under_q <= under_d;
    end
  end

  assign underrun_o = under_q;
`else
  assign underrun_o = 1'b0;
`endif

  always_comb begin
    stg_d = stg_q;
    if (valid_i && ch_ok) begin
      stg_d[ch_i] = data_i;
    end
  end

  // The copy reads stg_q, so a write on the boundary clock is not seen by this copy.
  always_comb begin
    fbuf_d = fbuf_q;
    fmt_d  = fmt_q;
    if (boundary) begin
      fmt_d = fmt_i;
      for (int i = 0; i < NCH; i++) begin
`ifdef DAC_TDM_UNDERRUN_EN
        fbuf_d[i] = wr_q[i] ? stg_q[i] : '0;
`else
        fbuf_d[i] = stg_q[i];
`endif
      end
    end
  end

  // Outputs are registered from next-state values, so they line up with the counter value they
  // describe. For example, slot 0 bit 0 of a new frame appears while cnt==0.
  always_comb begin
    fmt_eff = (fmt_d == 2'd3) ? FmtLj : fmt_d;
    sample  = fbuf_d[slot_d];
    word_lj = {sample, {(SLOT_W-DATA_W){1'b0}}};
    unique case (fmt_eff)
      FmtI2s:  word = word_lj >> 1;
      FmtRj:   word = {{(SLOT_W-DATA_W){1'b0}}, sample};
      default: word = word_lj;
    endcase
    idx    = BitMax - bit_d;
    data_d = word[idx];
    bck_d  = (ph_d >= PhHalf);
    if (NCH == 2) begin
      lrck_d = (fmt_eff == FmtI2s) ? (slot_d != '0) : (slot_d == '0);
    end else begin
      lrck_d = (slot_d == '0) && (bit_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q   <= '0;
      bit_q  <= '0;
      slot_q <= '0;
      fmt_q  <= '0;
      bck_q  <= 1'b0;
      lrck_q <= 1'b0;
      data_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        stg_q[i]  <= '0;
        fbuf_q[i] <= '0;
      end
    end else begin
      ph_q   <= ph_d;
      bit_q  <= bit_d;
      slot_q <= slot_d;
      fmt_q  <= fmt_d;
      bck_q  <= bck_d;
      lrck_q <= lrck_d;
      data_q <= data_d;
      for (int i = 0; i < NCH; i++) begin
        stg_q[i]  <= stg_d[i];
        fbuf_q[i] <= fbuf_d[i];
      end
    end
  end

  assign pop_o  = !rst && (ph_q == '0) && (bit_q == '0) && (slot_q == '0);
  assign sck_o  = clk;
  assign bck_o  = bck_q;
  assign lrck_o = lrck_q;
  assign data_o = data_q;

endmodule

// File: tb/tb_dac_tdm_drv.sv
// Self-checking bench for dac_tdm_drv.
// It drives a stereo instance (defaults) and an 8-channel TDM instance (BCK_DIV=4).
// Both instances are checked against a frame-level reference model.
module tb_dac_tdm_drv;
  localparam int DW  = 24;
  localparam int SW  = 32;
  localparam int N0  = 2;
  localparam int B0  = 2;
  localparam int N1  = 8;
  localparam int B1  = 4;
  localparam int FR0 = N0 * SW * B0;
  localparam int FR1 = N1 * SW * B1;
`ifdef DAC_TDM_UNDERRUN_EN
  localparam bit UND_EXP = 1'b1;
`else
  localparam bit UND_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    fmt0 = '0, fmt1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic          c0 = 1'b0;
  logic [2:0]    c1 = '0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic pop0, sck0, bck0, lr0, do0, un0;
  logic pop1, sck1, bck1, lr1, do1, un1;

  int n_run = 0;
  int n_fail = 0;

  // Reference model state, index 0 = stereo instance, 1 = TDM instance.
  int            mcnt   [2];
  bit            mfirst [2];
  logic [DW-1:0] mstg   [2][8];
  logic [DW-1:0] mfb    [2][8];
  bit            mwr    [2][8];
  logic [1:0]    mfmt   [2];
  bit            mund   [2];

  wire [5:0] obs0 = {sck0, pop0, bck0, lr0, do0, un0};
  wire [5:0] obs1 = {sck1, pop1, bck1, lr1, do1, un1};

  dac_tdm_drv u_dut0 (
    .clk(clk), .rst(rst), .fmt_i(fmt0), .data_i(d0), .ch_i(c0), .valid_i(v0),
    .pop_o(pop0), .sck_o(sck0), .bck_o(bck0), .lrck_o(lr0), .data_o(do0), .underrun_o(un0)
  );

  dac_tdm_drv #(.DATA_W(DW), .SLOT_W(SW), .NCH(N1), .BCK_DIV(B1)) u_dut1 (
    .clk(clk), .rst(rst), .fmt_i(fmt1), .data_i(d1), .ch_i(c1), .valid_i(v1),
    .pop_o(pop1), .sck_o(sck1), .bck_o(bck1), .lrck_o(lr1), .data_o(do1), .underrun_o(un1)
  );

  always #5 clk = ~clk;

  task automatic model_step(input int k, input logic v, input int ch, input logic [DW-1:0] d,
                            input logic [1:0] f);
    int nch;
    int frame;
    nch   = (k == 0) ? N0 : N1;
    frame = nch * SW * ((k == 0) ? B0 : B1);
    if (rst) begin
      mcnt[k] = 0; mfirst[k] = 1'b1; mfmt[k] = '0; mund[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        mstg[k][i] = '0; mfb[k][i] = '0; mwr[k][i] = 1'b0;
      end
      return;
    end
    if (mcnt[k] == frame - 1) begin
      for (int i = 0; i < nch; i++) begin
`ifdef DAC_TDM_UNDERRUN_EN
        mfb[k][i] = mwr[k][i] ? mstg[k][i] : '0;
        if (!mwr[k][i]) mund[k] = 1'b1;
`else
        mfb[k][i] = mstg[k][i];
`endif
        mwr[k][i] = 1'b0;
      end
      mfmt[k] = f;
    end
    if (v && ch < nch) begin
      mstg[k][ch] = d;
      mwr[k][ch]  = 1'b1;
    end
    mcnt[k]   = (mcnt[k] + 1) % frame;
    mfirst[k] = 1'b0;
  endtask

  always @(posedge clk) begin
    model_step(0, v0, int'(c0), d0, fmt0);
    model_step(1, v1, int'(c1), d1, fmt1);
  end

  // Expected {sck, pop, bck, lrck, data, underrun} at the falling edge for the current cnt.
  function automatic logic [5:0] exp_out(input int k);
    int bd, nch, p, bi, b, s, f;
    logic [DW-1:0] x;
    logic e_pop, e_bck, e_lr, e_d;
    bd    = (k == 0) ? B0 : B1;
    nch   = (k == 0) ? N0 : N1;
    e_pop = !rst && (mcnt[k] == 0);
    if (mfirst[k]) return {1'b0, e_pop, 3'b000, mund[k]};
    p  = mcnt[k] % bd;
    bi = mcnt[k] / bd;
    b  = bi % SW;
    s  = bi / SW;
    e_bck = (p >= bd / 2);
    x = mfb[k][s];
    f = (mfmt[k] == 2'd3) ? 0 : int'(mfmt[k]);
    e_d = 1'b0;
    if (f == 0 && b < DW) e_d = x[DW-1-b];
    if (f == 1 && b >= 1 && b <= DW) e_d = x[DW-b];
    if (f == 2 && b >= SW - DW) e_d = x[SW-1-b];
    if (nch == 2) e_lr = (f == 1) ? (s == 1) : (s == 0);
    else e_lr = (s == 0) && (b == 0);
    return {1'b0, e_pop, e_bck, e_lr, e_d, mund[k]};
  endfunction

  task automatic test_reset();
    logic [5:0] e;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      e = exp_out(0); n_run++;
      if (obs0 !== e) begin n_fail++; $display("FAIL reset_hold dut0 got=%b exp=%b", obs0, e); end
      e = exp_out(1); n_run++;
      if (obs1 !== e) begin n_fail++; $display("FAIL reset_hold dut1 got=%b exp=%b", obs1, e); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    e = exp_out(0); n_run++;
    if (obs0 !== e) begin n_fail++; $display("FAIL reset_release dut0 got=%b exp=%b", obs0, e); end
    e = exp_out(1); n_run++;
    if (obs1 !== e) begin n_fail++; $display("FAIL reset_release dut1 got=%b exp=%b", obs1, e); end
    n_run++;
    if ({pop0, pop1} !== 2'b11) begin
      n_fail++; $display("FAIL first_pop got=%b exp=11", {pop0, pop1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lj();
    logic [5:0] e;
    logic [DW-1:0] cap = '0;
    int fr = 0, last_pop = -1, c;
    fmt0 = 2'd0;
    for (c = 0; c < 3 * FR0; c++) begin
      v0 = (c < 2);
      c0 = (c == 1);
      d0 = (c == 1) ? 24'h123456 : 24'hABCDEF;
      @(negedge clk);
      e = exp_out(0); n_run++;
      if (obs0 !== e) begin
        n_fail++; $display("FAIL lj_frame cnt=%0d got=%b exp=%b", mcnt[0], obs0, e);
      end
      if (mcnt[0] == 0) fr++;
      if (fr == 1 && mcnt[0] % 2 == 1 && mcnt[0] < 2 * DW) cap = {cap[DW-2:0], do0};
      if (pop0 === 1'b1) begin
        if (last_pop >= 0) begin
          n_run++;
          if (c - last_pop != FR0) begin
            n_fail++; $display("FAIL lj_pop_period got=%0d exp=%0d", c - last_pop, FR0);
          end
        end
        last_pop = c;
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0;
    n_run++;
    if (cap !== 24'hABCDEF) begin n_fail++; $display("FAIL lj_slot0 got=%h exp=abcdef", cap); end
  endtask

  task automatic test_formats();
    logic [5:0] e;
    logic [DW-1:0] cap;
    int fr, lo, b;
    for (int f = 1; f <= 3; f++) begin
      fmt0 = 2'(f);
      fr = 0; cap = '0;
      lo = (f == 1) ? 1 : (f == 2) ? SW - DW : 0;
      for (int c = 0; c < 3 * FR0 && fr < 2; c++) begin
        @(negedge clk);
        e = exp_out(0); n_run++;
        if (obs0 !== e) begin
          n_fail++; $display("FAIL fmt%0d_frame cnt=%0d got=%b exp=%b", f, mcnt[0], obs0, e);
        end
        if (mcnt[0] == 0) fr++;
        b = mcnt[0] / 2;
        if (fr == 1 && mcnt[0] % 2 == 1 && b >= lo && b < lo + DW) cap = {cap[DW-2:0], do0};
        @(posedge clk); #1;
      end
      n_run++;
      if (cap !== 24'hABCDEF) begin
        n_fail++; $display("FAIL fmt%0d_slot0 got=%h exp=abcdef", f, cap);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] e;
    for (int c = 0; c < 6 * FR0; c++) begin
      v0 = ($urandom_range(0, 3) == 0);
      c0 = 1'($urandom);
      d0 = 24'($urandom);
      if ($urandom_range(0, 63) == 0) fmt0 = 2'($urandom_range(0, 3));
      @(negedge clk);
      e = exp_out(0); n_run++;
      if (obs0 !== e) begin
        n_fail++; $display("FAIL random cnt=%0d got=%b exp=%b", mcnt[0], obs0, e);
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0;
  endtask

  task automatic test_boundary_write();
    logic [5:0] e;
    logic [DW-1:0] cap_a = '0, cap_b = '0;
    bit st = 1'b0, bw = 1'b0;
    int fr = 0;
    fmt0 = 2'd0;
    for (int c = 0; c < 5 * FR0 && fr < 3; c++) begin
      v0 = 1'b0;
      if (!st && mcnt[0] == 10) begin v0 = 1'b1; c0 = 1'b0; d0 = 24'h111111; end
      if (!st && mcnt[0] == 11) begin v0 = 1'b1; c0 = 1'b1; d0 = 24'h222222; st = 1'b1; end
      if (st && !bw && mcnt[0] == FR0 - 1) begin
        v0 = 1'b1; c0 = 1'b0; d0 = 24'h7FFFFF; bw = 1'b1;
      end
      @(negedge clk);
      e = exp_out(0); n_run++;
      if (obs0 !== e) begin
        n_fail++; $display("FAIL bnd_write cnt=%0d got=%b exp=%b", mcnt[0], obs0, e);
      end
      if (bw && mcnt[0] == 0) fr++;
      if (mcnt[0] % 2 == 1 && mcnt[0] < 2 * DW) begin
        if (fr == 1) cap_a = {cap_a[DW-2:0], do0};
        if (fr == 2) cap_b = {cap_b[DW-2:0], do0};
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0;
    n_run++;
    if (cap_a !== 24'h111111) begin n_fail++; $display("FAIL bnd_old got=%h exp=111111", cap_a); end
    n_run++;
    if (cap_b !== 24'h7FFFFF) begin n_fail++; $display("FAIL bnd_new got=%h exp=7fffff", cap_b); end
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    int ones = 0;
    for (int c = 0; c < 2 * FR0 && mcnt[0] != FR0 / 2 + 20; c++) begin
      @(negedge clk);
      e = exp_out(0); n_run++;
      if (obs0 !== e) begin
        n_fail++; $display("FAIL rst_mid_pre cnt=%0d got=%b exp=%b", mcnt[0], obs0, e);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    e = exp_out(0); n_run++;
    if (obs0 !== e) begin n_fail++; $display("FAIL rst_mid_assert got=%b exp=%b", obs0, e); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_run++;
    if ({pop0, bck0, lr0, do0} !== 4'b1000) begin
      n_fail++; $display("FAIL rst_mid_release got=%b exp=1000", {pop0, bck0, lr0, do0});
    end
    for (int c = 0; c < 2 * FR0; c++) begin
      e = exp_out(0); n_run++;
      if (obs0 !== e) begin
        n_fail++; $display("FAIL rst_mid_post cnt=%0d got=%b exp=%b", mcnt[0], obs0, e);
      end
      if (do0 === 1'b1) ones++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    n_run++;
    if (ones != 0) begin n_fail++; $display("FAIL rst_mid_zero_data got=%0d exp=0", ones); end
  endtask

  task automatic test_underrun();
    logic [5:0] e;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4 * FR0; c++) begin
      v0 = (c == 5) || (c == 6) || (c == FR0 + 5);
      c0 = (c == 6);
      d0 = 24'($urandom);
      @(negedge clk);
      e = exp_out(0); n_run++;
      if (obs0 !== e) begin
        n_fail++; $display("FAIL underrun_frame cnt=%0d got=%b exp=%b", mcnt[0], obs0, e);
      end
      if (c == FR0 + 60) begin
        n_run++;
        if (un0 !== 1'b0) begin n_fail++; $display("FAIL underrun_early got=%b exp=0", un0); end
      end
      if (c == 2 * FR0 + 40 || c == 4 * FR0 - 1) begin
        n_run++;
        if (un0 !== UND_EXP) begin
          n_fail++; $display("FAIL underrun_flag c=%0d got=%b exp=%b", c, un0, UND_EXP);
        end
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0;
  endtask

  task automatic test_tdm();
    logic [5:0] e;
    logic [DW-1:0] cap = '0;
    int lr_cnt = 0, pops = 0, loc, bi, p;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3 * FR1; c++) begin
      v1 = (c >= 1 && c <= 8);
      c1 = 3'(c - 1);
      d1 = 24'(c);
      @(negedge clk);
      e = exp_out(1); n_run++;
      if (obs1 !== e) begin
        n_fail++; $display("FAIL tdm_frame cnt=%0d got=%b exp=%b", mcnt[1], obs1, e);
      end
      loc = c % FR1; bi = loc / B1; p = loc % B1;
      if (c / FR1 == 1 && lr1 === 1'b1) lr_cnt++;
      if (pop1 === 1'b1) pops++;
      if (c / FR1 == 1 && p == 2 && bi / SW == 3 && bi % SW < DW) cap = {cap[DW-2:0], do1};
      @(posedge clk); #1;
    end
    v1 = 1'b0;
    n_run++;
    if (lr_cnt != B1) begin n_fail++; $display("FAIL tdm_fsync_width got=%0d exp=%0d", lr_cnt, B1); end
    n_run++;
    if (pops != 3) begin n_fail++; $display("FAIL tdm_pop_count got=%0d exp=3", pops); end
    n_run++;
    if (cap !== 24'h000004) begin n_fail++; $display("FAIL tdm_slot3 got=%h exp=000004", cap); end
  endtask

  initial begin
    test_reset();
    test_lj();
    test_formats();
    test_random();
    test_boundary_write();
    test_reset_mid();
    test_underrun();
    test_tdm();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
